inst_axi_bridge: RTL and testbench

//  Converts the instruction-side SRAM-like fetch port (physical address after translation) into AXI4 read bursts.

---
 rtl/inst_axi_bridge_pkg.sv | 28 ++
 rtl/inst_axi_bridge_if.sv | 34 +++
 rtl/inst_axi_bridge.sv | 129 ++++++++++++
 tb/tb_inst_axi_bridge.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_axi_bridge_pkg.sv
// ============================================================================
// Module : inst_axi_bridge_pkg
// Brief  : Shared types and AXI constants for the instruction fetch bridge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package inst_axi_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0] C_BURST_INCR = 2'b01;
  localparam logic [2:0] C_SIZE_4B    = 3'b010;
  localparam logic [1:0] C_RESP_OKAY  = 2'b00;

  // The second word is skipped when it would land in the next 4KB page.
  function automatic logic [7:0] burst_len(input logic [9:0] word_in_page);
    return (word_in_page == 10'h3FF) ? 8'd0 : 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_axi_bridge_if.sv
// ============================================================================
// Module : inst_axi_bridge_if
// Brief  : AXI4 read address/data channels between fetch bridge and crossbar.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface inst_axi_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

`default_nettype wire

// File: rtl/inst_axi_bridge.sv
// ============================================================================
// Module : inst_axi_bridge
// Brief  : Turns a two-word instruction fetch into one AXI4 INCR read burst.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_axi_bridge
  import inst_axi_bridge_pkg::*;
#(
  parameter logic [3:0] ARID_VAL = 4'd0
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        sram_inst_ena,
  input  wire logic [31:0] sram_inst_addr,
  input  wire logic        flush,
  output logic      [31:0] sram_inst_rdata_1,
  output logic      [31:0] sram_inst_rdata_2,
  output logic             sram_inst_ok_1,
  output logic             sram_inst_ok_2,
  output logic             sram_inst_err,
  inst_axi_bridge_if.master axi
);

  state_t      r_state;
  logic        r_drop;
  logic        r_errflag;
  logic        r_beat;
  logic [7:0]  r_arlen;
  logic [31:0] r_araddr;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_ok_1;
  logic        r_ok_2;
  logic        r_err;
  logic [31:0] r_rdata_1;
  logic [31:0] r_rdata_2;

  logic w_err_next;
  logic w_kill;
  logic w_unused;

  assign w_err_next = r_errflag | (axi.rresp != C_RESP_OKAY);
  assign w_kill     = r_drop | flush;
  assign w_unused   = ^{axi.rid, sram_inst_addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_drop    <= 1'b0;
      r_errflag <= 1'b0;
      r_beat    <= 1'b0;
      r_arlen   <= 8'd0;
      r_araddr  <= 32'd0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_ok_1    <= 1'b0;
      r_ok_2    <= 1'b0;
      r_err     <= 1'b0;
      r_rdata_1 <= 32'd0;
      r_rdata_2 <= 32'd0;
    end else begin
      r_ok_1 <= 1'b0;
      r_ok_2 <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sram_inst_ena && !flush) begin
            r_araddr  <= sram_inst_addr;
            r_arlen   <= burst_len(sram_inst_addr[11:2]);
            r_arvalid <= 1'b1;
            r_beat    <= 1'b0;
            r_errflag <= 1'b0;
            r_state   <= S_AR;
          end
        end
        S_AR: begin
          if (flush) r_drop <= 1'b1;
          if (axi.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (flush) r_drop <= 1'b1;
          if (axi.rvalid) begin
            if (!r_beat) r_rdata_1 <= axi.rdata;
            else         r_rdata_2 <= axi.rdata;
            r_beat    <= 1'b1;
            r_errflag <= w_err_next;
            // Pulses are staged here so they are visible during the RESP cycle.
            if (axi.rlast) begin
              r_rready <= 1'b0;
              r_ok_1   <= ~w_kill;
              r_ok_2   <= ~w_kill & (r_arlen == 8'd1);
              r_err    <= ~w_kill & w_err_next;
              r_state  <= S_RESP;
            end
          end
        end
        S_RESP: begin
          r_drop  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A redirect arriving in the RESP cycle itself still suppresses the pulses.
  assign sram_inst_ok_1    = r_ok_1 & ~flush;
  assign sram_inst_ok_2    = r_ok_2 & ~flush;
  assign sram_inst_err     = r_err  & ~flush;
  assign sram_inst_rdata_1 = r_rdata_1;
  assign sram_inst_rdata_2 = r_rdata_2;

  assign axi.arid    = ARID_VAL;
  assign axi.araddr  = r_araddr;
  assign axi.arlen   = r_arlen;
  assign axi.arsize  = C_SIZE_4B;
  assign axi.arburst = C_BURST_INCR;
  assign axi.arvalid = r_arvalid;
  assign axi.rready  = r_rready;

endmodule

`default_nettype wire

// File: tb/tb_inst_axi_bridge.sv
// ============================================================================
// Module : tb_inst_axi_bridge
// Brief  : Scoreboard bench for inst_axi_bridge with a reactive AXI slave.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_inst_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [31:0] addr;
  logic        flush_drv;
  logic        s_flush;
  logic        flush;
  logic [31:0] rdata_1, rdata_2;
  logic        ok_1, ok_2, err;

  assign flush = flush_drv | s_flush;

  inst_axi_bridge_if bus();

  inst_axi_bridge #(.ARID_VAL(4'd0)) dut (
    .clk               (clk),
    .rst               (rst),
    .sram_inst_ena     (ena),
    .sram_inst_addr    (addr),
    .flush             (flush),
    .sram_inst_rdata_1 (rdata_1),
    .sram_inst_rdata_2 (rdata_2),
    .sram_inst_ok_1    (ok_1),
    .sram_inst_ok_2    (ok_2),
    .sram_inst_err     (err),
    .axi               (bus.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        ok2;
    logic        err;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;
  exp_t sb[$];
  exp_t m_e;
  int   ok_seen = 0;
  int   ok_cyc  = 0;

  // Slave configuration for the next burst, plus what it captured on AR.
  logic [31:0] s_d0, s_d1, s_exp_addr;
  logic [1:0]  s_r0, s_r1;
  int          s_stall;
  bit          s_flush_b0;
  bit          s_busy;
  logic [31:0] cap_addr;
  logic [7:0]  cap_len;
  logic [2:0]  cap_size;
  logic [1:0]  cap_burst;
  logic [3:0]  cap_id;

  initial begin
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    bus.rresp = '0; bus.rlast = 1'b0; bus.rid = '0;
    s_flush = 1'b0; s_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && bus.arvalid) begin
        s_busy = 1'b1;
        for (int i = 0; i < s_stall; i++) begin
          checks++;
          if (bus.arvalid !== 1'b1 || bus.araddr !== s_exp_addr) begin
            errors++;
            $display("FAIL ar_stable: arvalid=%b araddr=%h, required 1 / %h", bus.arvalid, bus.araddr, s_exp_addr);
          end
          @(negedge clk);
        end
        bus.arready = 1'b1;
        cap_addr = bus.araddr; cap_len = bus.arlen; cap_size = bus.arsize;
        cap_burst = bus.arburst; cap_id = bus.arid;
        @(negedge clk);
        bus.arready = 1'b0;
        for (int b = 0; b <= int'(cap_len) && rst; b++) begin
          bus.rvalid = 1'b1;
          bus.rdata  = (b == 0) ? s_d0 : s_d1;
          bus.rresp  = (b == 0) ? s_r0 : s_r1;
          bus.rlast  = (b == int'(cap_len));
          bus.rid    = 4'd5;
          if (b == 0 && s_flush_b0) s_flush = 1'b1;
          for (int w = 0; w < 10 && rst && bus.rready !== 1'b1; w++) @(negedge clk);
          if (!rst) break;
          checks++;
          if (bus.rready !== 1'b1) begin
            errors++;
            $display("FAIL rready_beat%0d: rready=%b, required 1", b, bus.rready);
          end
          @(negedge clk);
          s_flush = 1'b0;
        end
        bus.rvalid = 1'b0; bus.rlast = 1'b0; s_flush = 1'b0;
        s_busy = 1'b0;
      end
    end
  end

  // Scoreboard: every ok_1 pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (ok_1 === 1'b1) begin
        ok_seen++;
        ok_cyc = cyc;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ok: ok_1=1 with nothing outstanding (rdata_1=%h)", rdata_1);
        end else begin
          m_e = sb.pop_front();
          if (ok_2 !== m_e.ok2 || err !== m_e.err || rdata_1 !== m_e.d1) begin
            errors++;
            $display("FAIL resp: ok_2=%b err=%b rdata_1=%h, required %b %b %h", ok_2, err, rdata_1, m_e.ok2, m_e.err, m_e.d1);
          end
          if (m_e.ok2) begin
            checks++;
            if (rdata_2 !== m_e.d2) begin
              errors++;
              $display("FAIL rdata_2: got %h, required %h", rdata_2, m_e.d2);
            end
          end
        end
      end else if (ok_2 === 1'b1 || err === 1'b1) begin
        checks++; errors++;
        $display("FAIL stray_pulse: ok_2=%b err=%b without ok_1", ok_2, err);
      end
    end
  end

  task automatic setup_slave(input logic [31:0] a, d0, d1, input logic [1:0] r0, r1,
                             input int stall, input bit fl);
    s_exp_addr = a; s_d0 = d0; s_d1 = d1; s_r0 = r0; s_r1 = r1;
    s_stall = stall; s_flush_b0 = fl;
  endtask

  task automatic push_exp(input logic [31:0] a, d0, d1, input logic [1:0] r0, r1);
    exp_t e;
    bit two;
    two   = (a[11:2] != 10'h3FF);
    e.ok2 = two;
    e.err = (r0 != 2'b00) || (two && r1 != 2'b00);
    e.d1  = d0;
    e.d2  = d1;
    sb.push_back(e);
  endtask

  task automatic fetch(input logic [31:0] a, d0, d1, input logic [1:0] r0, r1,
                       input int stall, input bit fl, output int lat);
    int  ok0, t0;
    bit  seen_busy, done;
    logic [7:0] exp_len;
    exp_len = (a[11:2] == 10'h3FF) ? 8'd0 : 8'd1;
    setup_slave(a, d0, d1, r0, r1, stall, fl);
    if (!fl) push_exp(a, d0, d1, r0, r1);
    ok0 = ok_seen; seen_busy = 0; done = 0;
    @(negedge clk);
    ena = 1'b1; addr = a; t0 = cyc;
    @(negedge clk);
    ena = 1'b0;
    for (int w = 0; w < 80 && !done; w++) begin
      @(negedge clk);
      if (s_busy) seen_busy = 1;
      if (!fl && ok_seen != ok0) done = 1;
      if (fl && seen_busy && !s_busy) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: fetch of %h did not complete", a);
    end
    lat = ok_cyc - t0;
    checks++;
    if (cap_addr !== a || cap_len !== exp_len || cap_size !== 3'b010 ||
        cap_burst !== 2'b01 || cap_id !== 4'd0) begin
      errors++;
      $display("FAIL ar_fields: addr=%h len=%0d size=%b burst=%b id=%0d, required %h %0d 010 01 0",
               cap_addr, cap_len, cap_size, cap_burst, cap_id, a, exp_len);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; ena = 1'b0; addr = '0; flush_drv = 1'b0;
    setup_slave(32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.arvalid !== 1'b0 || bus.rready !== 1'b0 || ok_1 !== 1'b0 || ok_2 !== 1'b0 ||
        err !== 1'b0 || rdata_1 !== 32'd0 || rdata_2 !== 32'd0 || bus.araddr !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: arvalid=%b rready=%b ok=%b%b err=%b d1=%h d2=%h araddr=%h, required all 0",
               bus.arvalid, bus.rready, ok_1, ok_2, err, rdata_1, rdata_2, bus.araddr);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    fetch(32'h1FC0_0000, 32'h11, 32'h22, 2'b00, 2'b00, 0, 0, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL latency_min: got %0d, required 4", lat); end
    fetch(32'h0000_0FFC, 32'hAB, 32'hDEAD_BEEF, 2'b00, 2'b00, 0, 0, lat);
    fetch(32'h8000_1234, 32'hCAFE_0001, 32'hCAFE_0002, 2'b00, 2'b00, 0, 0, lat);
  endtask

  task automatic test_stall();
    int lat;
    fetch(32'h1FC0_0040, 32'h3333_3333, 32'h4444_4444, 2'b00, 2'b00, 5, 0, lat);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL latency_stall: got %0d, required 9", lat); end
  endtask

  task automatic test_flush();
    int lat;
    fetch(32'h0000_2000, 32'h5555_0000, 32'h5555_0004, 2'b00, 2'b00, 0, 1, lat);
    fetch(32'h0000_2008, 32'h6666_0000, 32'h6666_0004, 2'b00, 2'b00, 0, 0, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL after_flush_latency: got %0d, required 4", lat); end
    // A request presented together with a redirect in IDLE must be ignored.
    @(negedge clk);
    ena = 1'b1; flush_drv = 1'b1; addr = 32'h0000_3000;
    @(negedge clk);
    ena = 1'b0; flush_drv = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.arvalid !== 1'b0) begin
      errors++;
      $display("FAIL idle_flush_block: arvalid=%b, required 0", bus.arvalid);
    end
  endtask

  task automatic test_error();
    int lat;
    fetch(32'h0000_4000, 32'h7777_0000, 32'h7777_0004, 2'b00, 2'b10, 0, 0, lat);
    fetch(32'h0000_5FFC, 32'h8888_0000, 32'h0, 2'b11, 2'b00, 0, 0, lat);
  endtask

  task automatic test_reset_mid();
    int lat;
    bit hit;
    setup_slave(32'h0000_6000, 32'h9999_0000, 32'h9999_0004, 2'b00, 2'b00, 0, 0);
    hit = 0;
    @(negedge clk);
    ena = 1'b1; addr = 32'h0000_6000;
    @(negedge clk);
    ena = 1'b0;
    for (int w = 0; w < 20 && !hit; w++) begin
      if (bus.rready === 1'b1) hit = 1;
      else @(negedge clk);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL reset_mid_reach_r: rready never rose"); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.arvalid !== 1'b0 || bus.rready !== 1'b0 || ok_1 !== 1'b0 ||
        rdata_1 !== 32'd0 || rdata_2 !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: arvalid=%b rready=%b ok_1=%b d1=%h d2=%h, required all 0",
               bus.arvalid, bus.rready, ok_1, rdata_1, rdata_2);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    fetch(32'h0000_6100, 32'hAAAA_0000, 32'hAAAA_0004, 2'b00, 2'b00, 0, 0, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL after_reset_latency: got %0d, required 4", lat); end
  endtask

  task automatic test_back_to_back();
    int ok0, c_a, c_b;
    bit got;
    setup_slave(32'h0000_7000, 32'hBBBB_0000, 32'hBBBB_0004, 2'b00, 2'b00, 0, 0);
    push_exp(32'h0000_7000, 32'hBBBB_0000, 32'hBBBB_0004, 2'b00, 2'b00);
    push_exp(32'h0000_7000, 32'hBBBB_0000, 32'hBBBB_0004, 2'b00, 2'b00);
    ok0 = ok_seen; c_a = 0; c_b = 0;
    @(negedge clk);
    ena = 1'b1; addr = 32'h0000_7000;
    got = 0;
    for (int w = 0; w < 40 && !got; w++) begin
      @(negedge clk);
      if (ok_seen == ok0 + 1) begin got = 1; c_a = ok_cyc; end
    end
    got = 0;
    for (int w = 0; w < 10 && !got; w++) begin
      @(negedge clk);
      if (bus.arvalid === 1'b1) got = 1;
    end
    ena = 1'b0;
    got = 0;
    for (int w = 0; w < 40 && !got; w++) begin
      @(negedge clk);
      if (ok_seen == ok0 + 2) begin got = 1; c_b = ok_cyc; end
    end
    checks++;
    if (!got || c_b - c_a !== 5) begin
      errors++;
      $display("FAIL back_to_back: completed=%b ok spacing=%0d, required 1 / 5", got, c_b - c_a);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_error();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
